// File: rtl/lsu_pkg.sv
// lsu_pkg: funct3 encodings, FSM states and request legality check for the load/store unit
package lsu_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [2:0] {IDLE, LOAD, RMW_READ, WRITE, RESP} lsu_state_t;
  function automatic logic bad_access(input logic we, input logic [2:0] f3, input logic [1:0] off);
    return (we ? !(f3 inside {F3_B, F3_H, F3_W}) : !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU}))
      || (f3[1:0] == 2'b01 && off[0]) || (f3[1:0] == 2'b10 && off != 2'b00);
  endfunction
endpackage

// File: rtl/lsu_byte_lane.sv
// lsu_byte_lane: extracts/extends a load lane and merges sub-word store data into a word
module lsu_byte_lane (
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_rd,
  input  logic [15:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merged
);
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_mask;
  logic [31:0] w_ins;
  assign w_byte   = 8'(i_rd >> {i_off, 3'b000});
  assign w_half   = 16'(i_rd >> {i_off[1], 4'b0000});
  assign o_load   = i_funct3[1] ? i_rd
                  : i_funct3[0] ? {{16{~i_funct3[2] & w_half[15]}}, w_half}
                  : {{24{~i_funct3[2] & w_byte[7]}}, w_byte};
  assign w_mask   = i_funct3[0] ? 32'h0000_ffff << {i_off[1], 4'b0000} : 32'h0000_00ff << {i_off, 3'b000};
  assign w_ins    = i_funct3[0] ? {2{i_wdata}} : {4{i_wdata[7:0]}};
  assign o_merged = (i_rd & ~w_mask) | (w_ins & w_mask);
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store sequencer with read-modify-write for sub-word stores
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_we,
  output logic [31:0] mem_A,
  output logic [31:0] mem_WD,
  input  logic [31:0] mem_RD
);
  lsu_state_t  r_state;
  logic [2:0]  r_funct3;
  logic [1:0]  r_off;
  logic [15:0] r_wdata;
  logic        r_rsp_valid;
  logic        r_rsp_err;
  logic [31:0] r_rsp_rdata;
  logic        r_mem_we;
  logic [31:0] r_mem_a;
  logic [31:0] r_mem_wd;
  logic        w_err;
  logic [31:0] w_load;
  logic [31:0] w_merged;
  assign w_err     = bad_access(req_we, req_funct3, req_addr[1:0]) || (req_addr >= 32'(MEM_WORDS * 4));
  assign req_ready = (r_state == IDLE) && !reset;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rsp_rdata;
  assign mem_we    = r_mem_we;
  assign mem_A     = r_mem_a;
  assign mem_WD    = r_mem_wd;
  lsu_byte_lane u_lane (
    .i_funct3 (r_funct3),
    .i_off    (r_off),
    .i_rd     (mem_RD),
    .i_wdata  (r_wdata),
    .o_load   (w_load),
    .o_merged (w_merged)
  );
  // request sequencing; memory and response outputs are registered so each state drives them directly
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_funct3    <= '0;
      r_off       <= '0;
      r_wdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
      r_mem_we    <= 1'b0;
      r_mem_a     <= '0;
      r_mem_wd    <= '0;
    end else begin
      case (r_state)
        IDLE: if (req_valid) begin
          r_funct3 <= req_funct3;
          r_off    <= req_addr[1:0];
          r_wdata  <= req_wdata[15:0];
          if (w_err) begin
            r_state     <= RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_rsp_rdata <= '0;
          end else begin
            r_mem_a <= {req_addr[31:2], 2'b00};
            if (!req_we) r_state <= LOAD;
            else if (req_funct3 == F3_W) begin
              r_state  <= WRITE;
              r_mem_we <= 1'b1;
              r_mem_wd <= req_wdata;
            end else r_state <= RMW_READ;
          end
        end
        LOAD: begin
          r_rsp_rdata <= w_load;
          r_rsp_valid <= 1'b1;
          r_mem_a     <= '0;
          r_state     <= RESP;
        end
        RMW_READ: begin
          r_mem_wd <= w_merged;
          r_mem_we <= 1'b1;
          r_state  <= WRITE;
        end
        WRITE: begin
          r_mem_we    <= 1'b0;
          r_mem_wd    <= '0;
          r_mem_a     <= '0;
          r_rsp_valid <= 1'b1;
          r_state     <= RESP;
        end
        RESP: if (rsp_ready) begin
          r_rsp_valid <= 1'b0;
          r_rsp_err   <= 1'b0;
          r_rsp_rdata <= '0;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: randomized and directed checks of load_store_unit against a byte-level memory model
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_we;
  logic [31:0] mem_A;
  logic [31:0] mem_WD;
  logic [31:0] mem_RD;
  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];
  logic        init = 1'b0;
  int          n_vec = 0;
  int          n_err = 0;

  load_store_unit #(.MEM_WORDS(64)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mem_we(mem_we),
    .mem_A(mem_A), .mem_WD(mem_WD), .mem_RD(mem_RD)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input int i);
    return 32'(i) * 32'h9e37_79b1 ^ 32'h5a5a_0f0f;
  endfunction

  assign mem_RD = mem[mem_A[7:2]];

  // data memory: preload pattern on init, otherwise synchronous word write
  always @(posedge clk) begin
    if (init) for (int i = 0; i < 64; i++) mem[i] <= pat(i);
    else if (mem_we) mem[mem_A[7:2]] <= mem_WD;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd, output logic err, output int lat, output logic [31:0] word);
    int size, sh;
    logic legal;
    logic [31:0] w, m;
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    err   = !legal || (addr % size != 0) || addr >= 256;
    rd    = 0;
    word  = 0;
    lat   = 1;
    if (err) return;
    w  = ref_mem[addr[7:2]];
    sh = int'(addr % 4) * 8;
    m  = (size == 4) ? 32'hffff_ffff : 32'((1 << (size * 8)) - 1);
    if (!we) begin
      rd = (w >> sh) & m;
      if (!f3[2] && size < 4 && rd[size*8-1]) rd = rd | ~m;
      lat = 2;
    end else begin
      word = (w & ~(m << sh)) | ((wd & m) << sh);
      ref_mem[addr[7:2]] = word;
      lat = (size == 4) ? 2 : 3;
    end
  endtask

  task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                      output logic rdy, output logic [31:0] rd, output logic er, output int lat,
                      output int nwe, output int we_lat, output logic [31:0] wr_d, output logic [31:0] wr_a);
    @(negedge clk);
    rdy = req_ready;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; nwe = 0; we_lat = 0; wr_d = 0; wr_a = 0; rd = 'x; er = 1'bx;
    while (lat < 10) begin
      @(negedge clk);
      lat++;
      if (mem_we) begin nwe++; we_lat = lat; wr_d = mem_WD; wr_a = mem_A; end
      if (rsp_valid) begin rd = rsp_rdata; er = rsp_err; break; end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; init = 1'b1;
    for (int i = 0; i < 64; i++) ref_mem[i] = pat(i);
    @(posedge clk);
    #1 init = 1'b0;
    @(negedge clk);
    n_vec++;
    if (req_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready_held: got %b, required 0", req_ready); end
    reset = 1'b0;
    #1;
    n_vec++;
    if ({req_ready, rsp_valid, rsp_err, mem_we, rsp_rdata, mem_A, mem_WD} !== {1'b1, 3'b000, 96'h0}) begin
      n_err++;
      $display("FAIL reset_outputs: got rdy=%b rv=%b err=%b we=%b rd=%h A=%h WD=%h, required rdy=1 rest 0",
               req_ready, rsp_valid, rsp_err, mem_we, rsp_rdata, mem_A, mem_WD);
    end
  endtask

  task automatic test_store_word;
    logic rdy, er, e_err;
    logic [31:0] rd, wr_d, wr_a, e_rd, e_word;
    int lat, nwe, we_lat, e_lat;
    model(1'b1, 3'b010, 32'h10, 32'hdead_beef, e_rd, e_err, e_lat, e_word);
    xact(1'b1, 3'b010, 32'h10, 32'hdead_beef, rdy, rd, er, lat, nwe, we_lat, wr_d, wr_a);
    n_vec++;
    if ({nwe, we_lat} !== {32'd1, 32'd1}) begin n_err++; $display("FAIL sw_we: got count=%0d at=%0d, required 1 at 1", nwe, we_lat); end
    n_vec++;
    if ({wr_a, wr_d} !== {32'h10, 32'hdead_beef}) begin n_err++; $display("FAIL sw_data: got A=%h WD=%h, required 00000010 deadbeef", wr_a, wr_d); end
    n_vec++;
    if (lat != 2 || er !== 1'b0) begin n_err++; $display("FAIL sw_rsp: got lat=%0d err=%b, required 2 0", lat, er); end
  endtask

  task automatic test_loads;
    logic [2:0]  f3 [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
    logic [31:0] ad [4] = '{32'h13, 32'h13, 32'h10, 32'h12};
    logic [31:0] ex [4] = '{32'hffff_ffde, 32'h0000_00de, 32'hffff_beef, 32'h0000_dead};
    logic rdy, er;
    logic [31:0] rd, wr_d, wr_a;
    int lat, nwe, we_lat;
    for (int i = 0; i < 4; i++) begin
      xact(1'b0, f3[i], ad[i], 32'h0, rdy, rd, er, lat, nwe, we_lat, wr_d, wr_a);
      n_vec++;
      if (rd !== ex[i] || er !== 1'b0 || lat != 2 || nwe != 0) begin
        n_err++;
        $display("FAIL load_%0d: got rd=%h err=%b lat=%0d we=%0d, required rd=%h err=0 lat=2 we=0", i, rd, er, lat, nwe, ex[i]);
      end
    end
  endtask

  task automatic test_subword_store;
    logic rdy, er, e_err;
    logic [31:0] rd, wr_d, wr_a, e_rd, e_word;
    int lat, nwe, we_lat, e_lat;
    model(1'b1, 3'b000, 32'h11, 32'h55, e_rd, e_err, e_lat, e_word);
    xact(1'b1, 3'b000, 32'h11, 32'h55, rdy, rd, er, lat, nwe, we_lat, wr_d, wr_a);
    n_vec++;
    if (wr_d !== 32'hdead_55ef || we_lat != 2 || lat != 3 || nwe != 1) begin
      n_err++;
      $display("FAIL sb_merge: got WD=%h at=%0d lat=%0d we=%0d, required dead55ef 2 3 1", wr_d, we_lat, lat, nwe);
    end
    model(1'b1, 3'b001, 32'h12, 32'h1234, e_rd, e_err, e_lat, e_word);
    xact(1'b1, 3'b001, 32'h12, 32'h1234, rdy, rd, er, lat, nwe, we_lat, wr_d, wr_a);
    n_vec++;
    if (wr_d !== 32'h1234_55ef || wr_a !== 32'h10 || lat != 3) begin
      n_err++;
      $display("FAIL sh_merge: got WD=%h A=%h lat=%0d, required 123455ef 00000010 3", wr_d, wr_a, lat);
    end
    xact(1'b0, 3'b010, 32'h10, 32'h0, rdy, rd, er, lat, nwe, we_lat, wr_d, wr_a);
    n_vec++;
    if (rd !== 32'h1234_55ef) begin n_err++; $display("FAIL lw_readback: got %h, required 123455ef", rd); end
  endtask

  task automatic test_errors;
    logic        we [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [2:0]  f3 [4] = '{3'b010, 3'b001, 3'b010, 3'b011};
    logic [31:0] ad [4] = '{32'h06, 32'h01, 32'h100, 32'h0};
    logic rdy, er;
    logic [31:0] rd, wr_d, wr_a;
    int lat, nwe, we_lat;
    for (int i = 0; i < 4; i++) begin
      xact(we[i], f3[i], ad[i], 32'hffff_ffff, rdy, rd, er, lat, nwe, we_lat, wr_d, wr_a);
      n_vec++;
      if (er !== 1'b1 || rd !== 32'h0 || nwe != 0 || lat != 1) begin
        n_err++;
        $display("FAIL error_%0d: got err=%b rd=%h we=%0d lat=%0d, required err=1 rd=0 we=0 lat=1", i, er, rd, nwe, lat);
      end
    end
  endtask

  task automatic test_back_to_back;
    int k;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10; req_wdata = 0;
    rsp_ready = 1'b0;
    @(posedge clk);
    #1 req_funct3 = 3'b100; req_addr = 32'h13;
    k = 0;
    do begin @(negedge clk); k++; end while (!rsp_valid && k < 10);
    n_vec++;
    if (k != 2) begin n_err++; $display("FAIL bp_latency: got %0d, required 2", k); end
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if ({rsp_valid, rsp_rdata, req_ready} !== {1'b1, 32'h1234_55ef, 1'b0}) begin
        n_err++;
        $display("FAIL bp_hold_%0d: got rv=%b rd=%h rdy=%b, required 1 123455ef 0", i, rsp_valid, rsp_rdata, req_ready);
      end
      if (i < 4) @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({req_ready, rsp_valid} !== 2'b10) begin n_err++; $display("FAIL b2b_idle: got rdy=%b rv=%b, required 1 0", req_ready, rsp_valid); end
    @(posedge clk);
    #1 req_valid = 1'b0;
    k = 0;
    do begin @(negedge clk); k++; end while (!rsp_valid && k < 10);
    n_vec++;
    if (k != 2 || rsp_rdata !== 32'h0000_0012 || rsp_err !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_rsp: got lat=%0d rd=%h err=%b, required 2 00000012 0", k, rsp_rdata, rsp_err);
    end
  endtask

  task automatic test_random;
    logic we, rdy, er, e_err;
    logic [2:0] f3;
    logic [31:0] addr, wd, rd, wr_d, wr_a, e_rd, e_word;
    int lat, nwe, we_lat, e_lat, r;
    for (int t = 0; t < 200; t++) begin
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) f3 = 3'($urandom_range(0, 7));
      else if (we) f3 = 3'($urandom_range(0, 2));
      else begin r = $urandom_range(0, 4); f3 = (r > 2) ? 3'(r + 1) : 3'(r); end
      r = $urandom_range(0, 9);
      addr = (r == 0) ? 32'($urandom_range(256, 1023)) : (r == 1) ? $urandom : 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) begin
        if (f3[1]) addr[1:0] = 2'b00;
        else if (f3[0]) addr[0] = 1'b0;
      end
      wd = $urandom;
      model(we, f3, addr, wd, e_rd, e_err, e_lat, e_word);
      xact(we, f3, addr, wd, rdy, rd, er, lat, nwe, we_lat, wr_d, wr_a);
      n_vec++;
      if (rdy !== 1'b1) begin n_err++; $display("FAIL rnd_ready t=%0d: got %b, required 1", t, rdy); end
      n_vec++;
      if ({er, rd} !== {e_err, e_rd}) begin
        n_err++;
        $display("FAIL rnd_rsp t=%0d we=%b f3=%b a=%h: got err=%b rd=%h, required err=%b rd=%h", t, we, f3, addr, er, rd, e_err, e_rd);
      end
      n_vec++;
      if (lat != e_lat || nwe != ((we && !e_err) ? 1 : 0)) begin
        n_err++;
        $display("FAIL rnd_timing t=%0d: got lat=%0d we=%0d, required lat=%0d we=%0d", t, lat, nwe, e_lat, (we && !e_err) ? 1 : 0);
      end
      if (we && !e_err) begin
        n_vec++;
        if ({wr_a, wr_d} !== {addr & 32'hffff_fffc, e_word} || we_lat != e_lat - 1) begin
          n_err++;
          $display("FAIL rnd_write t=%0d: got A=%h WD=%h at=%0d, required A=%h WD=%h at=%0d",
                   t, wr_a, wr_d, we_lat, addr & 32'hffff_fffc, e_word, e_lat - 1);
        end
      end
    end
    @(negedge clk);
    for (int i = 0; i < 64; i++) begin
      n_vec++;
      if (mem[i] !== ref_mem[i]) begin n_err++; $display("FAIL mem_word_%0d: got %h, required %h", i, mem[i], ref_mem[i]); end
    end
  endtask

  task automatic test_reset_abort;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h21; req_wdata = 32'haa;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if (mem_we !== 1'b1) begin n_err++; $display("FAIL abort_in_write: got mem_we=%b, required 1", mem_we); end
    reset = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({mem_we, rsp_valid, req_ready} !== 3'b000) begin
      n_err++;
      $display("FAIL abort_reset: got we=%b rv=%b rdy=%b, required 0 0 0", mem_we, rsp_valid, req_ready);
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_vec++;
      if ({req_ready, rsp_valid, mem_we} !== 3'b100) begin
        n_err++;
        $display("FAIL abort_after_%0d: got rdy=%b rv=%b we=%b, required 1 0 0", i, req_ready, rsp_valid, mem_we);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_loads();
    test_subword_store();
    test_errors();
    test_back_to_back();
    test_random();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
